matmul_ctrl: RTL and testbench
==============================

MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter N, default 2, meaning matrix dimension and PE chain length (N>=2).
REQ-002 SHALL have parameter AW, default 2, meaning PE local-memory address width (2^AW >= N).
REQ-003 SHALL have port clk  input  1  meaning single system clock, rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning job request, sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  meaning high in every state except IDLE.
REQ-007 SHALL have port done  output  1  meaning one-cycle job-complete pulse.
REQ-008 SHALL have port mem_addr  output  2*AW  meaning source buffer word index, i*N+j.
REQ-009 SHALL have port mem_sel  output  1  meaning source buffer select, 0=A, 1=B.
REQ-010 SHALL have port mem_data  input  32  meaning IEEE-754 single word, valid the cycle after mem_addr.
REQ-011 SHALL have port pe_a  output  32  meaning A operand to first PE.
REQ-012 SHALL have port pe_b  output  32  meaning B operand to first PE.
REQ-013 SHALL have port pe_stb  output  1  meaning operand strobe to first PE.
REQ-014 SHALL have port pe_b_valid  output  1  meaning pe_b carries a weight load.
REQ-015 SHALL have port pe_addr  output  AW  meaning PE local-memory write address.
REQ-016 SHALL have port pe_mem_select  output  1  meaning PE weight bank select.
REQ-017 SHALL have port pe_ack  input  1  meaning first PE input acknowledge.
REQ-018 SHALL have port res_c  input  32  meaning result word from last PE.
REQ-019 SHALL have port res_stb  input  1  meaning res_c valid.
REQ-020 SHALL have port res_ack  output  1  meaning controller accepts res_c.
REQ-021 SHALL have ports res_wr_en (output, 1), res_wr_addr (output, 2*AW) and res_wr_data (output, 32), meaning result buffer write.

Function
REQ-022 SHALL implement FSM states IDLE, B_RD, B_CAP, B_SEND, A_RD, A_CAP, A_SEND, DRAIN, DONE.
REQ-023 SHALL move IDLE->B_RD on start=1 and ignore start in every other state.
REQ-024 SHALL drive mem_addr with word counter k in *_RD; SHALL register mem_data into pe_b (B phase) or pe_a (A phase) in *_CAP.
REQ-025 SHALL hold pe_stb=1 with stable data in *_SEND; transfer occurs on an edge with pe_stb=1 and pe_ack=1; SHALL ignore pe_ack otherwise.
REQ-026 SHALL advance SEND->RD with k+1 after a transfer, giving a minimum of 3 cycles per word.
REQ-027 B phase: mem_sel=1, pe_b_valid=1, pe_addr=k mod N, N*N words; SHALL go to A_RD with k=0 after word N*N-1.
REQ-028 A phase: mem_sel=0, pe_b_valid=0, N*N words row-major; SHALL go to DRAIN after word N*N-1.
REQ-029 SHALL drive pe_mem_select from a bank register for the whole job; SHALL toggle the bank on DONE.
REQ-030 SHALL drive res_ack=1 in A_RD, A_CAP, A_SEND and DRAIN, and res_ack=0 elsewhere.
REQ-031 SHALL, on each edge with res_stb=1 and res_ack=1, pulse res_wr_en, write res_wr_addr=r and res_wr_data=res_c, and increment result counter r.
REQ-032 SHALL count a result that coincides with the last A transfer.
REQ-033 SHALL go DRAIN->DONE on the edge where r reaches N*N; DONE SHALL last 1 cycle with done=1 and then go to IDLE.
REQ-034 SHALL keep counters wide enough (2*AW+1 bits) that N*N does not wrap.

Reset
REQ-035 SHALL, while rst=1, at the next edge force state to IDLE, k=0, r=0 and bank=0, with every output 0.
REQ-036 SHALL, on rst mid-job, abort the job, generate no done pulse and write no further results.

Verification
REQ-037 Reset: rst=1 for 2 cycles -> all outputs 0, busy=0, pe_mem_select=0.
REQ-038 Load B (N=2, pe_ack=1, B=1.0,2.0,3.0,4.0): start -> pe_b=3F800000, 40000000, 40400000, 40800000; pe_addr 0,1,0,1; pe_b_valid=1; one word every 3 cycles.
REQ-039 Back-pressure: pe_ack=0 for 5 cycles during A word 1 -> pe_stb=1 and pe_a held, mem_addr not advanced, resumes one cycle after pe_ack=1.
REQ-040 Results: 4 res_stb words (C0..C3) -> res_wr_addr 0..3 with matching data, done high exactly 1 cycle after the 4th accept, busy=0 the cycle after, bank=1.
REQ-041 Protocol: res_stb=1 during B phase -> res_ack=0, no write; start while busy -> ignored.
REQ-042 Abort: rst=1 in A_SEND -> IDLE next edge, outputs 0, no done, next job starts with bank 0.

Source files
------------

// File: rtl/matmul_ctrl.sv
// Job controller for a systolic PE chain. It streams N*N B weights and then N*N A
// operands from the source buffers, and collects N*N results into the result buffer.
module matmul_ctrl #(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [2*AW-1:0] mem_addr,
  output logic            mem_sel,
  input  logic [31:0]     mem_data,
  output logic [31:0]     pe_a,
  output logic [31:0]     pe_b,
  output logic            pe_stb,
  output logic            pe_b_valid,
  output logic [AW-1:0]   pe_addr,
  output logic            pe_mem_select,
  input  logic            pe_ack,
  input  logic [31:0]     res_c,
  input  logic            res_stb,
  output logic            res_ack,
  output logic            res_wr_en,
  output logic [2*AW-1:0] res_wr_addr,
  output logic [31:0]     res_wr_data
);

  localparam int unsigned MW = 2 * AW;
  localparam int unsigned KW = 2 * AW + 1;
  localparam logic [KW-1:0] NN_K   = KW'(N * N);
  localparam logic [KW-1:0] LAST_K = KW'(N * N - 1);
  localparam logic [KW-1:0] N_K    = KW'(N);

  typedef enum logic [3:0] {
    IDLE, B_RD, B_CAP, B_SEND, A_RD, A_CAP, A_SEND, DRAIN, DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   w_k_nxt;
  logic [KW-1:0]   r_r;
  logic [KW-1:0]   w_r_nxt;
  logic            r_bank;
  logic            w_xfer;
  logic            w_acc;
  logic            w_nb;
  logic            w_na;
  logic            w_nsend;
  logic            w_nack;

  logic            r_busy;
  logic            r_done;
  logic [MW-1:0]   r_mem_addr;
  logic            r_mem_sel;
  logic [31:0]     r_pe_a;
  logic [31:0]     r_pe_b;
  logic            r_pe_stb;
  logic            r_pe_b_valid;
  logic [AW-1:0]   r_pe_addr;
  logic            r_res_ack;
  logic            r_res_wr_en;
  logic [MW-1:0]   r_res_wr_addr;
  logic [31:0]     r_res_wr_data;

  // State, word counter, result counter and weight bank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_r     <= '0;
      r_bank  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_r     <= w_r_nxt;
      if (r_state == DONE) r_bank <= ~r_bank;
    end
  end

  // Next state; a result landing on the last A transfer is still counted
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_xfer      = ((r_state == B_SEND) || (r_state == A_SEND)) && pe_ack;
    w_acc       = res_stb && (r_state inside {A_RD, A_CAP, A_SEND, DRAIN});
    w_r_nxt     = r_r + KW'(w_acc);
    case (r_state)
      IDLE: begin
        w_r_nxt = '0;
        if (start) begin
          w_state_nxt = B_RD;
          w_k_nxt     = '0;
        end
      end
      B_RD:  w_state_nxt = B_CAP;
      B_CAP: w_state_nxt = B_SEND;
      B_SEND: begin
        if (w_xfer) begin
          if (r_k == LAST_K) begin
            w_state_nxt = A_RD;
            w_k_nxt     = '0;
          end else begin
            w_state_nxt = B_RD;
            w_k_nxt     = r_k + KW'(1);
          end
        end
      end
      A_RD:  w_state_nxt = A_CAP;
      A_CAP: w_state_nxt = A_SEND;
      A_SEND: begin
        if (w_xfer) begin
          if (r_k == LAST_K) begin
            w_state_nxt = DRAIN;
            w_k_nxt     = '0;
          end else begin
            w_state_nxt = A_RD;
            w_k_nxt     = r_k + KW'(1);
          end
        end
      end
      DRAIN: if (w_r_nxt >= NN_K) w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = IDLE;
        w_r_nxt     = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_nb    = w_state_nxt inside {B_RD, B_CAP, B_SEND};
    w_na    = w_state_nxt inside {A_RD, A_CAP, A_SEND};
    w_nsend = (w_state_nxt == B_SEND) || (w_state_nxt == A_SEND);
    w_nack  = w_na || (w_state_nxt == DRAIN);
  end

  // Outputs are registered from next-state values so they line up with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_sel     <= 1'b0;
      r_pe_a        <= '0;
      r_pe_b        <= '0;
      r_pe_stb      <= 1'b0;
      r_pe_b_valid  <= 1'b0;
      r_pe_addr     <= '0;
      r_res_ack     <= 1'b0;
      r_res_wr_en   <= 1'b0;
      r_res_wr_addr <= '0;
      r_res_wr_data <= '0;
    end else begin
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (w_state_nxt == DONE);
      r_mem_addr   <= (w_nb || w_na) ? MW'(w_k_nxt) : '0;
      r_mem_sel    <= w_nb;
      r_pe_b_valid <= w_nb;
      r_pe_addr    <= w_nb ? AW'(w_k_nxt % N_K) : '0;
      r_pe_stb     <= w_nsend;
      r_res_ack    <= w_nack;
      r_res_wr_en  <= w_acc;
      if (r_state == B_CAP) r_pe_b <= mem_data;
      if (r_state == A_CAP) r_pe_a <= mem_data;
      if (w_acc) begin
        r_res_wr_addr <= MW'(r_r);
        r_res_wr_data <= res_c;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign mem_addr      = r_mem_addr;
  assign mem_sel       = r_mem_sel;
  assign pe_a          = r_pe_a;
  assign pe_b          = r_pe_b;
  assign pe_stb        = r_pe_stb;
  assign pe_b_valid    = r_pe_b_valid;
  assign pe_addr       = r_pe_addr;
  assign pe_mem_select = r_bank;
  assign res_ack       = r_res_ack;
  assign res_wr_en     = r_res_wr_en;
  assign res_wr_addr   = r_res_wr_addr;
  assign res_wr_data   = r_res_wr_data;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Randomized bench for matmul_ctrl. An edge-indexed transaction model predicts
// transfers, result writes, done timing and the bank.
`timescale 1ns/1ps
module tb_matmul_ctrl;

  localparam int N      = 2;
  localparam int AW     = 2;
  localparam int NN     = N * N;
  localparam int MW     = 2 * AW;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [MW-1:0] mem_addr;
  logic          mem_sel;
  logic [31:0]   mem_data;
  logic [31:0]   pe_a;
  logic [31:0]   pe_b;
  logic          pe_stb;
  logic          pe_b_valid;
  logic [AW-1:0] pe_addr;
  logic          pe_mem_select;
  logic          pe_ack;
  logic [31:0]   res_c;
  logic          res_stb;
  logic          res_ack;
  logic          res_wr_en;
  logic [MW-1:0] res_wr_addr;
  logic [31:0]   res_wr_data;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            ec      = 0;
  bit            bank    = 1'b0;
  logic [31:0]   mem_a [2**MW];
  logic [31:0]   mem_b [2**MW];
  logic [31:0]   b_fix [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic          p_sel  = 1'b0;
  logic [MW-1:0] p_addr = '0;

  matmul_ctrl #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_data(mem_data),
    .pe_a(pe_a), .pe_b(pe_b), .pe_stb(pe_stb), .pe_b_valid(pe_b_valid),
    .pe_addr(pe_addr), .pe_mem_select(pe_mem_select), .pe_ack(pe_ack),
    .res_c(res_c), .res_stb(res_stb), .res_ack(res_ack),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ec++;
  endtask

  // Source buffer with one cycle of read latency
  task automatic drive_mem();
    mem_data = p_sel ? mem_b[p_addr] : mem_a[p_addr];
    p_sel    = mem_sel;
    p_addr   = mem_addr;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"},  64'(busy), 64'(0));
    check({tag, ".done"},  64'(done), 64'(0));
    check({tag, ".maddr"}, 64'(mem_addr), 64'(0));
    check({tag, ".msel"},  64'(mem_sel), 64'(0));
    check({tag, ".pe_a"},  64'(pe_a), 64'(0));
    check({tag, ".pe_b"},  64'(pe_b), 64'(0));
    check({tag, ".stb"},   64'(pe_stb), 64'(0));
    check({tag, ".bval"},  64'(pe_b_valid), 64'(0));
    check({tag, ".paddr"}, 64'(pe_addr), 64'(0));
    check({tag, ".bank"},  64'(pe_mem_select), 64'(0));
    check({tag, ".rack"},  64'(res_ack), 64'(0));
    check({tag, ".wren"},  64'(res_wr_en), 64'(0));
    check({tag, ".wraddr"}, 64'(res_wr_addr), 64'(0));
    check({tag, ".wrdata"}, 64'(res_wr_data), 64'(0));
  endtask

  task automatic idle_check();
    res_stb = 1'b1;
    res_c   = $urandom;
    for (int i = 0; i < 2; i++) begin
      step();
      check("idle.busy", 64'(busy), 64'(0));
      check("idle.done", 64'(done), 64'(0));
      check("idle.rack", 64'(res_ack), 64'(0));
      check("idle.stb",  64'(pe_stb), 64'(0));
      check("idle.wren", 64'(res_wr_en), 64'(0));
      check("idle.bank", 64'(pe_mem_select), 64'(bank));
    end
    res_stb = 1'b0;
  endtask

  // ack_mode: 0 always ack, 1 random ack, 2 hold ack low 5 cycles on A word 1
  task automatic run_job(input int ack_mode, input bit abort, input bit fixed_b);
    int x = 0, s, ref_e, t_last = -1, ra = -1, e_done, acc = 0, bp = 0, cnt = 0;
    int wr_addr;
    bit xfer_p = 1'b0, acc_p = 1'b0, wr_exp, exp_stb, exp_done, exp_ack;
    logic [31:0] acc_v = '0, wr_data;
    for (int i = 0; i < NN; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = fixed_b ? b_fix[i % 4] : $urandom;
    end
    start = 1'b1;
    s     = ec + 1;
    ref_e = s;
    while (1'b1) begin
      step();
      if (xfer_p) begin
        x++;
        ref_e = ec;
        if (x == 2 * NN) t_last = ec;
      end
      wr_exp  = acc_p;
      wr_data = acc_v;
      wr_addr = acc;
      if (acc_p) begin
        acc++;
        if (acc == NN) ra = ec;
      end
      e_done   = (t_last >= 0 && ra >= 0) ? ((ra > t_last) ? ra : t_last + 1) : -1;
      exp_done = (e_done == ec);
      exp_stb  = (x < 2 * NN) && (ec >= ref_e + 2);
      exp_ack  = (x >= NN) && !(e_done >= 0 && ec >= e_done);

      check("busy",    64'(busy), 64'(1));
      check("done",    64'(done), 64'(exp_done));
      check("pe_stb",  64'(pe_stb), 64'(exp_stb));
      check("res_ack", 64'(res_ack), 64'(exp_ack));
      check("bank",    64'(pe_mem_select), 64'(bank));
      check("wr_en",   64'(res_wr_en), 64'(wr_exp));
      if (wr_exp) begin
        check("wr_addr", 64'(res_wr_addr), 64'(wr_addr));
        check("wr_data", 64'(res_wr_data), 64'(wr_data));
      end
      if (x < NN) begin
        check("b.mem_sel", 64'(mem_sel), 64'(1));
        check("b.bvalid",  64'(pe_b_valid), 64'(1));
        check("b.mem_addr", 64'(mem_addr), 64'(x));
        check("b.pe_addr", 64'(pe_addr), 64'(x % N));
        if (exp_stb) check("b.pe_b", 64'(pe_b), 64'(mem_b[x]));
      end else if (x < 2 * NN) begin
        check("a.mem_sel", 64'(mem_sel), 64'(0));
        check("a.bvalid",  64'(pe_b_valid), 64'(0));
        check("a.mem_addr", 64'(mem_addr), 64'(x - NN));
        if (exp_stb) check("a.pe_a", 64'(pe_a), 64'(mem_a[x - NN]));
      end

      if (exp_done) begin
        start = 1'b0; res_stb = 1'b0; pe_ack = 1'b0;
        bank  = ~bank;
        break;
      end
      if (abort && exp_stb && x == NN + 1) begin
        rst = 1'b1; start = 1'b0; res_stb = 1'b1;
        step();
        check_zero("abort");
        rst  = 1'b0;
        bank = 1'b0;
        break;
      end
      cnt++;
      if (cnt > BUDGET) begin
        check("timeout", 64'(0), 64'(1));
        start = 1'b0; res_stb = 1'b0;
        break;
      end

      case (ack_mode)
        0: pe_ack = 1'b1;
        1: pe_ack = ($urandom % 2) == 0;
        default: begin
          if (exp_stb && x == NN + 1 && bp < 5) begin
            pe_ack = 1'b0;
            bp++;
          end else begin
            pe_ack = 1'b1;
          end
        end
      endcase
      res_stb = (acc < NN) && (($urandom % 3) == 0);
      res_c   = $urandom;
      start   = ($urandom % 4) == 0;
      drive_mem();
      xfer_p = exp_stb && pe_ack;
      acc_p  = exp_ack && res_stb;
      acc_v  = res_c;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_data = '0; pe_ack = 1'b0; res_c = '0; res_stb = 1'b0;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;

    run_job(0, 1'b0, 1'b1);
    idle_check();
    run_job(2, 1'b0, 1'b0);
    idle_check();
    repeat (3) begin
      run_job(1, 1'b0, 1'b0);
      idle_check();
    end
    run_job(1, 1'b1, 1'b0);
    idle_check();
    run_job(0, 1'b0, 1'b0);
    idle_check();
    run_job(1, 1'b0, 1'b0);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
